uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning enabled clock cycles per UART bit (>=4).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning rx synchronizer depth (>=2).
REQ-003 SHALL have port clk  input  1  system clock, rising edge; the block uses this one clock only.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ce  input  1  clock enable for the bit-timing counter and FSM.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port rx_data  output  8  received byte, stable while rx_valid=1.
REQ-008 SHALL have port rx_valid  output  1  byte available to the downstream boot loader.
REQ-009 SHALL have port rx_ready  input  1  downstream accepts; transfer when rx_valid&rx_ready.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun_err  output  1  one-cycle pulse when a completed byte is dropped.
REQ-012 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 SHALL pass rx through SYNC_STAGES flops; all logic uses the synchronized value rxs.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP; counter cnt and bit index advance only when ce=1.
REQ-015 IDLE: on rxs 1->0 (with ce=1) SHALL go to START with cnt=0.
REQ-016 START: at cnt=CLKS_PER_BIT/2 (integer division) SHALL sample rxs; 1 -> false start, back to IDLE, no output; 0 -> DATA, cnt=0, index=0.
REQ-017 DATA: at cnt=CLKS_PER_BIT-1 SHALL shift rxs into bit[index] (LSB first), clear cnt; after index 7 go to STOP.
REQ-018 STOP: at cnt=CLKS_PER_BIT-1 SHALL sample rxs and return to IDLE the same edge (half bit early, so back-to-back frames are caught).
REQ-019 Stop sample=1 SHALL load rx_data and set rx_valid on that edge; stop sample=0 SHALL pulse frame_err, discard the byte, leave rx_valid unchanged.
REQ-020 rx_valid SHALL stay high, rx_data unchanged, until a cycle with rx_ready=1; it then clears on that edge.
REQ-021 Byte completes while rx_valid=1 and rx_ready=0: SHALL keep the old byte, drop the new one, pulse overrun_err.
REQ-022 Byte completes in the same cycle as an accept: SHALL load the new byte, rx_valid stays 1, no overrun.
REQ-023 Handshake (REQ-020..022) SHALL operate regardless of ce.
REQ-024 After a frame error the FSM SHALL require a fresh 1->0 edge on rxs; a held-low line (break) SHALL not retrigger.
REQ-025 Latency: rx_valid SHALL be high the cycle after the stop-bit sample edge.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, cnt=0, index=0, shift register 0, rx_data=0x00, rx_valid=0, frame_err=0, overrun_err=0, busy=0.
REQ-027 Synchronizer flops SHALL reset to 1 (idle line) so deassertion cannot fake a start edge.
REQ-028 Reset mid-frame SHALL discard the partial byte; the next complete frame SHALL be received normally.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum, the default CLKS_PER_BIT, and frame constants (8 data bits, 1 stop bit).
REQ-030 The synchronizer SHALL be a sub-module sync_ff (parameter SYNC_STAGES, reset value 1).

Verification (CLKS_PER_BIT=8, ce=1 unless stated)
REQ-031 Frame 0xA5, rx_ready=1 -> rx_valid one cycle, rx_data=0xA5, frame_err=0, overrun_err=0.
REQ-032 rx low for 2 clocks only -> START samples 1, no rx_valid, busy returns 0, FSM in IDLE.
REQ-033 Frame 0x3C with stop bit 0 -> frame_err one-cycle pulse, rx_valid stays 0; line held low 40 clocks, then frame 0x5A -> rx_data=0x5A.
REQ-034 rx_ready=0, frames 0x11 then 0x22 back-to-back -> rx_data=0x11 held, overrun_err pulse at 0x22 stop; raise rx_ready -> 0x11 accepted, rx_valid drops.
REQ-035 rst_n low during DATA bit 4 -> all outputs 0 at once; after release, frame 0x5A -> rx_data=0x5A.
REQ-036 ce high every other cycle, bit period 16 clocks, frame 0xC3 -> rx_data=0xC3; rx_ready pulsed while ce=0 still clears rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, default bit timing
// and the 8N1 frame shape.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // 10 MHz / 115200 baud, rounded
  localparam int UART_CLKS_PER_BIT_DEF = 87;
  localparam int UART_DATA_BITS        = 8;
  localparam int UART_STOP_BITS        = 1;
  localparam int UART_FRAME_BITS       = 1 + UART_DATA_BITS + UART_STOP_BITS;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for the asynchronous rx line. Resets to 1 so the
// idle line level is presented while and after reset.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the raw input through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '1;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready output handshake, frame-error and
// overrun pulses. Bit timing advances only on ce; the handshake runs every clock.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  uart_state_e               r_state;
  uart_state_e               w_state_nxt;
  logic                      w_rxs;
  logic                      r_rxs_prev;
  logic [CNT_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [7:0]                r_rx_data;
  logic                      r_rx_valid;
  logic                      r_frame_err;
  logic                      r_overrun_err;
  logic                      w_busy;
  logic                      w_stop_tick;
  logic                      w_frame_ok;
  logic                      w_frame_bad;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (rx),
    .o_q  (w_rxs)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state: start edge, mid-start check, 8 data bits, mid-stop exit
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (ce && r_rxs_prev && !w_rxs) w_state_nxt = ST_START;
      ST_START: if (ce && (r_cnt == CNT_HALF)) w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
      ST_DATA:  if (ce && (r_cnt == CNT_LAST) && (r_idx == IDX_LAST)) w_state_nxt = ST_STOP;
      ST_STOP:  if (ce && (r_cnt == CNT_LAST)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: busy flag and stop-bit sample strobes
  always_comb begin
    w_busy      = (r_state != ST_IDLE);
    w_stop_tick = ce && (r_state == ST_STOP) && (r_cnt == CNT_LAST);
    w_frame_ok  = w_stop_tick && w_rxs;
    w_frame_bad = w_stop_tick && !w_rxs;
  end

  // Bit timing, bit index, data shift and edge-detect history (ce-gated);
  // the history only updates on ce so an edge is seen on the enabled timeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxs_prev <= 1'b1;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
    end else if (ce) begin
      r_rxs_prev <= w_rxs;
      unique case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
        end
        ST_START: begin
          r_cnt <= (r_cnt == CNT_HALF) ? '0 : r_cnt + CNT_W'(1);
          r_idx <= '0;
        end
        ST_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rxs;
            r_idx          <= r_idx + IDX_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_STOP: r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
        default: r_cnt <= '0;
      endcase
    end
  end

  // Output handshake and error pulses (every clock, independent of ce)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_frame_err   <= w_frame_bad;
      r_overrun_err <= 1'b0;
      if (w_frame_ok) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun_err <= 1'b1;
        end
      end else if (rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
  assign busy        = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are generated bit by bit, and received
// bytes/pulses are compared against expectations derived from the frames sent.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ce       = 1'b1;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // observations gathered each negedge
  logic [7:0] acc_q[$];
  int         n_vld_cyc  = 0;
  int         n_ferr_cyc = 0;
  int         n_ovr_cyc  = 0;
  bit         busy_seen  = 1'b0;
  bit         ce_half    = 1'b0;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // clock-enable generator: constant 1, or toggling every clock
  initial forever begin
    @(posedge clk);
    #1;
    if (ce_half) ce = ~ce;
    else         ce = 1'b1;
  end

  // monitor: record transfers and pulse widths
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (rx_valid)    n_vld_cyc++;
      if (frame_err)   n_ferr_cyc++;
      if (overrun_err) n_ovr_cyc++;
      if (busy)        busy_seen = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_obs();
    acc_q.delete();
    n_vld_cyc  = 0;
    n_ferr_cyc = 0;
    n_ovr_cyc  = 0;
    busy_seen  = 1'b0;
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    step(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk, input int gap);
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bclk);
    drive_bit(stop, bclk);
    if (gap > 0) drive_bit(1'b1, gap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    step(3);
    checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun_err); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    step(4);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_q[$];
    clear_obs();
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'($urandom_range(0, 255)));
    exp_q.push_back(8'($urandom_range(0, 255)));
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, CPB, CPB);
    step(2 * CPB);
    checks++; if (acc_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", acc_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= acc_q.size() || acc_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_byte%0d got=%h exp=%h", i, (i < acc_q.size()) ? acc_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (n_vld_cyc !== exp_q.size()) begin errors++; $display("FAIL basic_valid_cycles got=%0d exp=%0d", n_vld_cyc, exp_q.size()); end
    checks++; if (n_ferr_cyc !== 0) begin errors++; $display("FAIL basic_frame_err got=%0d exp=0", n_ferr_cyc); end
    checks++; if (n_ovr_cyc !== 0)  begin errors++; $display("FAIL basic_overrun got=%0d exp=0", n_ovr_cyc); end
  endtask

  task automatic test_false_start();
    clear_obs();
    rx_ready = 1'b1;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 3 * CPB);
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL fstart_busy_seen got=%b exp=1", busy_seen); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL fstart_busy got=%b exp=0", busy); end
    checks++; if (n_vld_cyc !== 0)    begin errors++; $display("FAIL fstart_valid got=%0d exp=0", n_vld_cyc); end
    checks++; if (n_ferr_cyc !== 0)   begin errors++; $display("FAIL fstart_frame_err got=%0d exp=0", n_ferr_cyc); end
  endtask

  task automatic test_frame_err();
    clear_obs();
    rx_ready = 1'b1;
    send_frame(8'h3C, 1'b0, CPB, 0);
    drive_bit(1'b0, 40);
    checks++; if (n_ferr_cyc !== 1) begin errors++; $display("FAIL ferr_pulse_cycles got=%0d exp=1", n_ferr_cyc); end
    checks++; if (n_vld_cyc !== 0)  begin errors++; $display("FAIL ferr_valid got=%0d exp=0", n_vld_cyc); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL ferr_break_busy got=%b exp=0", busy); end
    drive_bit(1'b1, CPB);
    send_frame(8'h5A, 1'b1, CPB, 2 * CPB);
    checks++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h5A) begin
      errors++; $display("FAIL ferr_recover got_n=%0d got=%h exp=5a", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 8'hxx);
    end
    checks++; if (n_ferr_cyc !== 1) begin errors++; $display("FAIL ferr_no_retrigger got=%0d exp=1", n_ferr_cyc); end
  endtask

  task automatic test_overrun();
    logic [7:0] a, b;
    a = 8'h11;
    b = 8'h22;
    clear_obs();
    rx_ready = 1'b0;
    send_frame(a, 1'b1, CPB, 0);
    send_frame(b, 1'b1, CPB, 2 * CPB);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_data !== a)     begin errors++; $display("FAIL ovr_data_held got=%h exp=%h", rx_data, a); end
    checks++; if (n_ovr_cyc !== 1)   begin errors++; $display("FAIL ovr_pulse got=%0d exp=1", n_ovr_cyc); end
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(1);
    checks++; if (acc_q.size() !== 1 || acc_q[0] !== a) begin
      errors++; $display("FAIL ovr_accept got_n=%0d got=%h exp=%h", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 8'hxx, a);
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop got=%b exp=0", rx_valid); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] p;
    p = 8'h5A;
    clear_obs();
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b1, CPB, 2 * CPB);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre_valid got=%b exp=1", rx_valid); end
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(p[i], CPB);
    drive_bit(p[4], CPB / 2);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL mrst_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL mrst_data got=%h exp=00", rx_data); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mrst_busy got=%b exp=0", busy); end
    checks++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin
      errors++; $display("FAIL mrst_errs got=%b%b exp=00", frame_err, overrun_err);
    end
    rx = 1'b1;
    step(3);
    rst_n = 1'b1;
    clear_obs();
    rx_ready = 1'b1;
    step(CPB);
    send_frame(8'h5A, 1'b1, CPB, 2 * CPB);
    checks++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h5A) begin
      errors++; $display("FAIL mrst_recover got_n=%0d got=%h exp=5a", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 8'hxx);
    end
  endtask

  task automatic test_ce();
    logic [7:0] r;
    bit found;
    clear_obs();
    ce_half  = 1'b1;
    rx_ready = 1'b0;
    step(2);
    send_frame(8'hC3, 1'b1, 2 * CPB, 4 * CPB);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin
      errors++; $display("FAIL ce_data got=%b/%h exp=1/c3", rx_valid, rx_data);
    end
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (ce == 1'b0) found = 1'b1;
      else step(1);
    end
    checks++; if (!found) begin errors++; $display("FAIL ce_wait got=timeout exp=ce_low"); end
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ce_accept_ce0 got=%b exp=0", rx_valid); end
    checks++; if (acc_q.size() !== 1 || acc_q[0] !== 8'hC3) begin
      errors++; $display("FAIL ce_accept_byte got_n=%0d exp=c3", acc_q.size());
    end
    r = 8'($urandom_range(0, 255));
    rx_ready = 1'b1;
    send_frame(r, 1'b1, 2 * CPB, 4 * CPB);
    checks++; if (acc_q.size() !== 2 || acc_q[1] !== r) begin
      errors++; $display("FAIL ce_random got_n=%0d got=%h exp=%h", acc_q.size(), (acc_q.size() > 1) ? acc_q[1] : 8'hxx, r);
    end
    ce_half = 1'b0;
    step(4);
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_ferr;
    logic [7:0] b;
    logic       stop;
    clear_obs();
    exp_ferr = 0;
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      if (stop) exp_q.push_back(b);
      else      exp_ferr++;
      send_frame(b, stop, CPB, stop ? int'($urandom_range(0, 12)) : CPB + int'($urandom_range(0, 8)));
    end
    step(3 * CPB);
    checks++; if (acc_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", acc_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= acc_q.size() || acc_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_byte%0d got=%h exp=%h", i, (i < acc_q.size()) ? acc_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (n_ferr_cyc !== exp_ferr) begin errors++; $display("FAIL rand_frame_err got=%0d exp=%0d", n_ferr_cyc, exp_ferr); end
    checks++; if (n_vld_cyc !== exp_q.size()) begin errors++; $display("FAIL rand_valid_cycles got=%0d exp=%0d", n_vld_cyc, exp_q.size()); end
    checks++; if (n_ovr_cyc !== 0) begin errors++; $display("FAIL rand_overrun got=%0d exp=0", n_ovr_cyc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_mid_reset();
    test_ce();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
